show_sequencer: RTL and testbench

SHOW_SEQUENCER -- requirements
Module: show_sequencer

---
 rtl/show_pkg.sv | 15 +
 rtl/show_sequencer_if.sv | 14 +
 rtl/show_step_ctr.sv | 50 +++++
 rtl/show_sequencer.sv | 67 ++++++
 tb/tb_show_sequencer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/show_pkg.sv
// show_pkg: opcode, colour, sound, effect encodings and FSM/mode types for the show sequencer
package show_pkg;
    localparam logic [1:0] CLS_SYS = 2'b00, CLS_COLOR = 2'b01, CLS_SOUND = 2'b10, CLS_EFFECT = 2'b11;
    localparam logic [1:0] SYS_ON = 2'b00, SYS_RESET = 2'b01, SYS_STOP = 2'b10, SYS_RSVD = 2'b11;
    localparam logic [1:0] COLOR_GREEN = 2'b00, COLOR_PURPLE = 2'b01, COLOR_ORANGE = 2'b10, COLOR_OFF = 2'b11;
    localparam logic [1:0] SND_SCREAM = 2'b00, SND_CACKLE = 2'b01, SND_BOO = 2'b10, SND_SILENCE = 2'b11;
    localparam logic [1:0] EFF_WAVE = 2'b00, EFF_JAW = 2'b01, EFF_FOG = 2'b10, EFF_NONE = 2'b11;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
    typedef enum logic [1:0] {MODE_LOOP = 2'd0, MODE_ONESHOT = 2'd1, MODE_PINGPONG = 2'd2, MODE_LOOP_ALT = 2'd3} mode_t;

    function automatic logic [2:0] effect_onehot(input logic [1:0] code);
        return code == EFF_NONE ? 3'b000 : 3'b001 << code;
    endfunction
endpackage

// File: rtl/show_sequencer_if.sv
// show_sequencer_if: control, program-write and show-output signals of the show sequencer
interface show_sequencer_if #(parameter int NUM_STEPS = 8, parameter int DWELL_W = 8);
    localparam int AW = $clog2(NUM_STEPS);
    logic               start, stop, wr_en, busy, done, sound_trig;
    logic [1:0]         mode, color, sound_id;
    logic [DWELL_W-1:0] dwell;
    logic [AW-1:0]      wr_addr, step;
    logic [3:0]         wr_data, opcode;
    logic [2:0]         effect;
    modport master(output start, stop, mode, dwell, wr_en, wr_addr, wr_data,
                   input opcode, step, busy, done, color, sound_trig, sound_id, effect);
    modport slave(input start, stop, mode, dwell, wr_en, wr_addr, wr_data,
                  output opcode, step, busy, done, color, sound_trig, sound_id, effect);
endinterface

// File: rtl/show_step_ctr.sv
// show_step_ctr: dwell counter, step index and ping-pong direction; flags step entry and show end
module show_step_ctr import show_pkg::*; #(
    parameter int NUM_STEPS = 8,
    parameter int DWELL_W = 8,
    localparam int AW = $clog2(NUM_STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               run,
    input  logic               clear,
    input  logic               sys_reset,
    input  logic               sys_stop,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [AW-1:0]      step,
    output logic [AW-1:0]      nxt_step,
    output logic               step_entry,
    output logic               last_step
);
    localparam logic [AW-1:0] TOP = AW'(NUM_STEPS - 1);
    logic [DWELL_W-1:0] cnt;
    logic dir_down, nxt_down, adv, finish;

    always_comb begin
        adv = run && cnt == '0;
        finish = sys_stop || (mode == MODE_ONESHOT && step == TOP && !sys_reset);
        step_entry = go || (adv && !finish);
        last_step = adv && finish;
        nxt_down = 1'b0;
        nxt_step = '0;
        if (!go && !sys_reset) begin
            nxt_down = mode == MODE_PINGPONG && (dir_down ? step != '0 : step == TOP);
            nxt_step = nxt_down ? step - 1'b1 : step + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst || clear) begin
            cnt <= '0;
            step <= '0;
            dir_down <= 1'b0;
        end else if (step_entry) begin
            cnt <= dwell;
            step <= nxt_step;
            dir_down <= nxt_down;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
endmodule

// File: rtl/show_sequencer.sv
// show_sequencer: programmable haunted-show step sequencer driving colour, sound and effect outputs
module show_sequencer import show_pkg::*; #(
    parameter int NUM_STEPS = 8,
    parameter int DWELL_W = 8
) (
    input logic clk,
    input logic rst,
    show_sequencer_if.slave bus
);
    localparam int AW = $clog2(NUM_STEPS);
    state_t state;
    logic [3:0] mem [NUM_STEPS];
    logic [3:0] op, opcode;
    logic [AW-1:0] nxt_step;
    logic go, step_entry, last_step;
    logic [1:0] color, sound_id;
    logic [2:0] effect;
    logic sound_trig, done;

    assign go = bus.start && !bus.stop && state != ST_RUN;
    assign op = mem[nxt_step];

    show_step_ctr #(.NUM_STEPS(NUM_STEPS), .DWELL_W(DWELL_W)) u_ctr (
        .clk(clk), .rst(rst), .go(go), .run(state == ST_RUN), .clear(bus.stop),
        .sys_reset(opcode == {CLS_SYS, SYS_RESET}), .sys_stop(opcode == {CLS_SYS, SYS_STOP}),
        .mode(bus.mode), .dwell(bus.dwell), .step(bus.step), .nxt_step(nxt_step),
        .step_entry(step_entry), .last_step(last_step)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
        else if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

    // Memory is read before this edge's write lands, so an entering step sees old data.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            {opcode, color, sound_id, effect, sound_trig, done} <= '0;
        end else begin
            sound_trig <= 1'b0;
            done <= 1'b0;
            if (bus.stop) begin
                state <= ST_IDLE;
                {opcode, color, sound_id, effect} <= '0;
            end else if (last_step) begin
                state <= ST_DONE;
                done <= 1'b1;
                opcode <= '0;
                effect <= '0;
            end else if (step_entry) begin
                state <= ST_RUN;
                opcode <= op;
                color <= op[3:2] == CLS_COLOR ? op[1:0] : color;
                sound_trig <= op[3:2] == CLS_SOUND && op[1:0] != SND_SILENCE;
                sound_id <= op[3:2] == CLS_SOUND ? op[1:0] : sound_id;
                effect <= op[3:2] == CLS_EFFECT ? effect_onehot(op[1:0]) : 3'b000;
            end
        end

    assign bus.busy = state == ST_RUN;
    assign bus.opcode = opcode;
    assign bus.color = color;
    assign bus.sound_id = sound_id;
    assign bus.sound_trig = sound_trig;
    assign bus.effect = effect;
    assign bus.done = done;
endmodule

// File: tb/tb_show_sequencer.sv
// tb_show_sequencer: directed show programs with hand-computed step/output expectations
module tb_show_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    int errors = 0, checks = 0;

    show_sequencer_if #(.NUM_STEPS(4), .DWELL_W(8)) b();
    show_sequencer #(.NUM_STEPS(4), .DWELL_W(8)) dut(.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        b.wr_en = 1'b1;
        b.wr_addr = a;
        b.wr_data = d;
        tick();
        b.wr_en = 1'b0;
    endtask

    task automatic go();
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
    endtask

    task automatic halt();
        b.stop = 1'b1;
        tick();
        b.stop = 1'b0;
    endtask

    int pp [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int rs [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        {b.start, b.stop, b.wr_en, b.mode, b.dwell, b.wr_addr, b.wr_data} = '0;
        tick();
        tick();
        chk("rst_busy", 32'(b.busy), 0);
        chk("rst_opcode", 32'(b.opcode), 0);
        chk("rst_effect", 32'(b.effect), 0);
        rst = 1'b0;
        wr(0, 4'b0100); wr(1, 4'b1000); wr(2, 4'b1100); wr(3, 4'b0110);
        // loop, two cycles per step
        b.dwell = 1; b.mode = 2'b00;
        go();
        chk("loop_c0_busy", 32'(b.busy), 1);
        chk("loop_c0_step", 32'(b.step), 0);
        chk("loop_c0_opcode", 32'(b.opcode), 4);
        chk("loop_c0_color", 32'(b.color), 0);
        tick(); tick();
        chk("loop_c2_trig", 32'(b.sound_trig), 1);
        chk("loop_c2_id", 32'(b.sound_id), 0);
        tick();
        chk("loop_c3_trig", 32'(b.sound_trig), 0);
        tick();
        chk("loop_c4_effect", 32'(b.effect), 1);
        tick();
        chk("loop_c5_effect", 32'(b.effect), 1);
        tick();
        chk("loop_c6_effect", 32'(b.effect), 0);
        chk("loop_c6_color", 32'(b.color), 2);
        tick(); tick();
        chk("loop_c8_step", 32'(b.step), 0);
        chk("loop_c8_color", 32'(b.color), 0);
        halt();
        chk("stop_busy", 32'(b.busy), 0);
        chk("stop_opcode", 32'(b.opcode), 0);
        // one-shot, one cycle per step
        b.dwell = 0; b.mode = 2'b01;
        go();
        tick(); tick(); tick();
        chk("os_c3_step", 32'(b.step), 3);
        chk("os_c3_color", 32'(b.color), 2);
        chk("os_c3_done", 32'(b.done), 0);
        tick();
        chk("os_done", 32'(b.done), 1);
        chk("os_busy", 32'(b.busy), 0);
        chk("os_opcode", 32'(b.opcode), 0);
        chk("os_color", 32'(b.color), 2);
        tick();
        chk("os_done_pulse", 32'(b.done), 0);
        // ping-pong, restarted straight from DONE
        b.mode = 2'b10;
        go();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_step%0d", i), 32'(b.step), 32'(pp[i]));
            tick();
        end
        halt();
        // system RESET at step 2
        wr(2, 4'b0001);
        b.mode = 2'b00;
        go();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rs_step%0d", i), 32'(b.step), 32'(rs[i]));
            tick();
        end
        halt();
        // system STOP at step 1
        wr(1, 4'b0010);
        go();
        tick();
        chk("sp_c1_step", 32'(b.step), 1);
        tick();
        chk("sp_done", 32'(b.done), 1);
        chk("sp_busy", 32'(b.busy), 0);
        halt();
        // start and stop together from IDLE
        b.start = 1'b1; b.stop = 1'b1;
        tick();
        b.start = 1'b0; b.stop = 1'b0;
        chk("ss_busy", 32'(b.busy), 0);
        tick();
        chk("ss_busy2", 32'(b.busy), 0);
        // write to the slot being entered in the same cycle
        wr(1, 4'b1000);
        b.wr_en = 1'b1; b.wr_addr = 0; b.wr_data = 4'b1101;
        go();
        b.wr_en = 1'b0;
        chk("wr_old_opcode", 32'(b.opcode), 4);
        tick();
        chk("wr_c1_trig", 32'(b.sound_trig), 1);
        tick(); tick();
        chk("wr_new_opcode", 32'(b.opcode), 13);
        chk("wr_new_effect", 32'(b.effect), 2);
        // asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", 32'(b.busy), 0);
        chk("ar_opcode", 32'(b.opcode), 0);
        chk("ar_effect", 32'(b.effect), 0);
        chk("ar_done", 32'(b.done), 0);
        tick();
        rst = 1'b0;
        go();
        chk("ar_run_opcode", 32'(b.opcode), 0);
        tick();
        chk("ar_run_step", 32'(b.step), 1);
        chk("ar_mem_cleared", 32'(b.opcode), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
